// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the RV32I pipeline hazard/sequencing controller.
// Forwarding selects, controller FSM states and the register-match rule live here.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        PC_RUN      = 1'b0,
        PC_MEM_WAIT = 1'b1
    } pctrl_state_t;

    // x0 is hardwired to zero, so a write to it never produces a forwardable or hazardous value.
    function automatic logic rd_matches(input logic                  wr_en,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] rs);
        return wr_en && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source operand.
// The younger producer in MEM takes priority over the older one in WB.
module pipeline_ctrl_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_RegWrite_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_RegWrite_i,
    output fwd_sel_t              fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (rd_matches(mem_RegWrite_i, mem_rd_i, ex_rs_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (rd_matches(wb_RegWrite_i, wb_rd_i, ex_rs_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding, load-use
// bubbles, redirect flushes, data-memory wait freeze, stall counter and timeout flag.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rs1_i,
    input  logic [REG_ADDR_W-1:0] ex_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_MemRead_i,
    input  logic                  ex_redirect_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_RegWrite_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_RegWrite_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  stall_ex_o,
    output logic                  flush_id_o,
    output logic                  flush_ex_o,
    output fwd_sel_t              fwd_a_o,
    output fwd_sel_t              fwd_b_o,
    output logic [PERF_W-1:0]     stall_cycles_o,
    output logic                  err_timeout_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    pctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic              err_timeout_q, err_timeout_d;

    logic load_use;
    logic stall_if, stall_id, stall_ex, flush_id, flush_ex;

    pipeline_ctrl_fwd_unit u_fwd_a (
        .ex_rs_i        (ex_rs1_i),
        .mem_rd_i       (mem_rd_i),
        .mem_RegWrite_i (mem_RegWrite_i),
        .wb_rd_i        (wb_rd_i),
        .wb_RegWrite_i  (wb_RegWrite_i),
        .fwd_sel_o      (fwd_a_o)
    );

    pipeline_ctrl_fwd_unit u_fwd_b (
        .ex_rs_i        (ex_rs2_i),
        .mem_rd_i       (mem_rd_i),
        .mem_RegWrite_i (mem_RegWrite_i),
        .wb_rd_i        (wb_rd_i),
        .wb_RegWrite_i  (wb_RegWrite_i),
        .fwd_sel_o      (fwd_b_o)
    );

    assign load_use = rd_matches(ex_MemRead_i && id_use_rs1_i, ex_rd_i, id_rs1_i) ||
                      rd_matches(ex_MemRead_i && id_use_rs2_i, ex_rd_i, id_rs2_i);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        err_timeout_d = err_timeout_q;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        stall_ex      = 1'b0;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;

        case (state_q)
            PC_RUN: begin
                if (dmem_req_i && !dmem_ready_i) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    state_d    = PC_MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else if (ex_redirect_i) begin
                    // The load-use consumer sits in ID and is flushed by the redirect anyway.
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end

            PC_MEM_WAIT: begin
                // EX is frozen here, so a redirect in EX is picked up again once back in RUN.
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                if (wait_cnt_q == TIMEOUT_CNT) begin
                    err_timeout_d = 1'b1;
                end
                if (dmem_ready_i || !dmem_req_i) begin
                    state_d    = PC_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != TIMEOUT_CNT) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = PC_RUN;
                wait_cnt_d = '0;
            end
        endcase

        stall_cycles_d = stall_cycles_q + PERF_W'(stall_if);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= PC_RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign stall_if_o     = stall_if;
    assign stall_id_o     = stall_id;
    assign stall_ex_o     = stall_ex;
    assign flush_id_o     = flush_id;
    assign flush_ex_o     = flush_ex;
    assign stall_cycles_o = stall_cycles_q;
    assign err_timeout_o  = err_timeout_q;

    // Withdrawing a data-memory request mid-wait is a MEM-stage protocol violation.
    assert property (@(posedge clk) disable iff (rst)
                     (state_q == PC_MEM_WAIT) |-> dmem_req_i);

endmodule
